// File: rtl/jesd_loopback_mux.sv
// JESD loopback selector: picks the ADC-side output from link ADC data,
// narrowed and delayed DAC data, a ramp pattern or zeros, with blanked
// mode switching and a sticky gap flag for the loopback source.
module jesd_loopback_mux #(
   parameter int NUM_LANES = 4,
   parameter int DAC_W     = 32,
   parameter int ADC_W     = 16,
   parameter int DEPTH     = 16,
   parameter int BLANK_CYC = 8
) (
   input  logic                          link_clk,
   input  logic                          rst,
   input  logic [1:0]                    ctrl_mode,
   input  logic [$clog2(DEPTH)-1:0]      ctrl_delay,
   input  logic                          status_clr,
   input  logic                          dac_valid,
   input  logic [NUM_LANES*DAC_W-1:0]    dac_data,
   input  logic                          adc_valid_in,
   input  logic [NUM_LANES*ADC_W-1:0]    adc_data_in,
   output logic                          adc_valid,
   output logic [NUM_LANES*ADC_W-1:0]    adc_data,
   output logic [1:0]                    status_mode,
   output logic                          status_switching,
   output logic                          status_gap
);

   localparam int DATA_W = NUM_LANES * ADC_W;
   localparam int BC_W   = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;

   localparam logic [1:0] MODE_BYPASS = 2'b00;
   localparam logic [1:0] MODE_LOOP   = 2'b01;
   localparam logic [1:0] MODE_RAMP   = 2'b10;
   localparam logic [1:0] MODE_ZERO   = 2'b11;

   typedef enum logic {RUN, BLANK} state_t;

   state_t              state_reg, state_next;
   logic [1:0]          mode_reg, mode_next;
   logic [1:0]          pending_reg, pending_next;
   logic [BC_W-1:0]     blank_cnt_reg, blank_cnt_next;
   logic [ADC_W-1:0]    ramp_cnt_reg, ramp_cnt_next;
   logic [DATA_W-1:0]   out_data_reg, out_data_next;
   logic                out_valid_reg, out_valid_next;
   logic                gap_reg, gap_next;

   logic [DATA_W-1:0]   narrow_data;
   logic [DATA_W-1:0]   ramp_data;
   logic [DATA_W-1:0]   dl_data [DEPTH];
   logic [DEPTH-1:0]    dl_valid;
   logic [DATA_W-1:0]   tap_data;
   logic                tap_valid;

   // Per-lane round-half-up narrowing; only the positive side can overflow.
   for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      logic [ADC_W-1:0] top;
      logic             rnd;
      logic [ADC_W:0]   sum;
      assign top = dac_data[gi*DAC_W + DAC_W - 1 -: ADC_W];
      assign rnd = dac_data[gi*DAC_W + DAC_W - ADC_W - 1];
      assign sum = {top[ADC_W-1], top} + {{ADC_W{1'b0}}, rnd};
      assign narrow_data[gi*ADC_W +: ADC_W] = (sum[ADC_W] != sum[ADC_W-1]) ?
                                              {1'b0, {(ADC_W-1){1'b1}}} : sum[ADC_W-1:0];
      assign ramp_data[gi*ADC_W +: ADC_W] = ramp_cnt_reg + ADC_W'(gi);
   end

   // Entry 0 is the narrowing register; the tap at ctrl_delay=0 gives latency 2.
   assign tap_data  = dl_data[ctrl_delay];
   assign tap_valid = dl_valid[ctrl_delay];

   // Delay line shifts every cycle regardless of the applied mode.
   always_ff @(posedge link_clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            dl_data[i] <= '0;
         end
         dl_valid <= '0;
      end else begin
         dl_data[0]  <= dac_valid ? narrow_data : '0;
         dl_valid[0] <= dac_valid;
         for (int i = 1; i < DEPTH; i++) begin
            dl_data[i] <= dl_data[i-1];
         end
         dl_valid[DEPTH-1:1] <= dl_valid[DEPTH-2:0];
      end
   end

   // Mode FSM: a change restarts the blank; the pending mode is applied at its end.
   always_comb begin
      state_next     = state_reg;
      mode_next      = mode_reg;
      pending_next   = pending_reg;
      blank_cnt_next = blank_cnt_reg;
      case (state_reg)
         RUN: begin
            if (ctrl_mode != mode_reg) begin
               state_next     = BLANK;
               pending_next   = ctrl_mode;
               blank_cnt_next = '0;
            end
         end
         BLANK: begin
            if (ctrl_mode != pending_reg) begin
               pending_next   = ctrl_mode;
               blank_cnt_next = '0;
            end else if (blank_cnt_reg == BC_W'(BLANK_CYC - 1)) begin
               state_next = RUN;
               mode_next  = pending_reg;
            end else begin
               blank_cnt_next = blank_cnt_reg + 1'b1;
            end
         end
         default: state_next = RUN;
      endcase
   end

   // Output select follows the mode that will be applied after this edge,
   // so the new mode's data lands on the first cycle after the blank.
   always_comb begin
      out_data_next  = '0;
      out_valid_next = 1'b0;
      ramp_cnt_next  = '0;
      if (state_next == RUN) begin
         case (mode_next)
            MODE_BYPASS: begin
               out_data_next  = adc_data_in;
               out_valid_next = adc_valid_in;
            end
            MODE_LOOP: begin
               out_data_next  = tap_data;
               out_valid_next = tap_valid;
            end
            MODE_RAMP: begin
               out_data_next  = ramp_data;
               out_valid_next = 1'b1;
               ramp_cnt_next  = ramp_cnt_reg + 1'b1;
            end
            MODE_ZERO: begin
               out_valid_next = 1'b1;
            end
            default: out_valid_next = 1'b0;
         endcase
      end
      gap_next = ((state_reg == RUN) && (mode_reg == MODE_LOOP) && !tap_valid) ||
                 (gap_reg && !status_clr);
   end

   // State and output registers.
   always_ff @(posedge link_clk) begin
      if (rst) begin
         state_reg     <= RUN;
         mode_reg      <= MODE_BYPASS;
         pending_reg   <= MODE_BYPASS;
         blank_cnt_reg <= '0;
         ramp_cnt_reg  <= '0;
         out_data_reg  <= '0;
         out_valid_reg <= 1'b0;
         gap_reg       <= 1'b0;
      end else begin
         state_reg     <= state_next;
         mode_reg      <= mode_next;
         pending_reg   <= pending_next;
         blank_cnt_reg <= blank_cnt_next;
         ramp_cnt_reg  <= ramp_cnt_next;
         out_data_reg  <= out_data_next;
         out_valid_reg <= out_valid_next;
         gap_reg       <= gap_next;
      end
   end

   assign adc_data         = out_data_reg;
   assign adc_valid        = out_valid_reg;
   assign status_mode      = mode_reg;
   assign status_switching = (state_reg == BLANK);
   assign status_gap       = gap_reg;

endmodule

// File: tb/tb_jesd_loopback_mux.sv
// Directed bench for jesd_loopback_mux with default parameters.
module tb_jesd_loopback_mux;

   logic          link_clk = 1'b0;
   logic          rst;
   logic [1:0]    ctrl_mode;
   logic [3:0]    ctrl_delay;
   logic          status_clr;
   logic          dac_valid;
   logic [127:0]  dac_data;
   logic          adc_valid_in;
   logic [63:0]   adc_data_in;
   logic          adc_valid;
   logic [63:0]   adc_data;
   logic [1:0]    status_mode;
   logic          status_switching;
   logic          status_gap;

   int checks = 0;
   int errors = 0;

   jesd_loopback_mux dut (
      .link_clk         (link_clk),
      .rst              (rst),
      .ctrl_mode        (ctrl_mode),
      .ctrl_delay       (ctrl_delay),
      .status_clr       (status_clr),
      .dac_valid        (dac_valid),
      .dac_data         (dac_data),
      .adc_valid_in     (adc_valid_in),
      .adc_data_in      (adc_data_in),
      .adc_valid        (adc_valid),
      .adc_data         (adc_data),
      .status_mode      (status_mode),
      .status_switching (status_switching),
      .status_gap       (status_gap)
   );

   always #5 link_clk = ~link_clk;

   task automatic tick;
      @(posedge link_clk);
      #1;
   endtask

   task automatic test_reset;
      rst = 1'b1; ctrl_mode = 2'b00; ctrl_delay = 4'd0; status_clr = 1'b0;
      dac_valid = 1'b0; dac_data = '0;
      adc_valid_in = 1'b1; adc_data_in = 64'hABCD_ABCD_ABCD_ABCD;
      tick; tick;
      checks++; if (adc_data !== 64'h0) begin errors++; $display("FAIL reset_data: got %h expected 0", adc_data); end
      checks++; if (adc_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", adc_valid); end
      checks++; if (status_mode !== 2'b00) begin errors++; $display("FAIL reset_mode: got %b expected 00", status_mode); end
      checks++; if (status_switching !== 1'b0) begin errors++; $display("FAIL reset_switching: got %b expected 0", status_switching); end
      checks++; if (status_gap !== 1'b0) begin errors++; $display("FAIL reset_gap: got %b expected 0", status_gap); end
      $display("test_reset: outputs cleared under reset");
   endtask

   task automatic test_bypass;
      logic [63:0] vec [3];
      vec[0] = 64'h0000_0000_0000_1234;
      vec[1] = 64'h8000_7FFF_0001_FFFF;
      vec[2] = 64'h0102_0304_0506_0708;
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         adc_data_in = vec[i]; adc_valid_in = (i != 1);
         tick;
         checks++; if (adc_data !== vec[i]) begin errors++; $display("FAIL bypass_data[%0d]: got %h expected %h", i, adc_data, vec[i]); end
         checks++; if (adc_valid !== (i != 1)) begin errors++; $display("FAIL bypass_valid[%0d]: got %b expected %b", i, adc_valid, (i != 1)); end
         checks++; if (status_mode !== 2'b00) begin errors++; $display("FAIL bypass_mode[%0d]: got %b expected 00", i, status_mode); end
         $display("test_bypass: in=%h out=%h valid=%b", vec[i], adc_data, adc_valid);
      end
   endtask

   task automatic test_loopback_narrow;
      logic [127:0] din [3];
      logic [63:0]  exp [3];
      din[0] = {96'h0, 32'h1234_8000}; exp[0] = 64'h0000_0000_0000_1235;
      din[1] = {96'h0, 32'h7FFF_8000}; exp[1] = 64'h0000_0000_0000_7FFF;
      din[2] = {96'h0, 32'hFFFF_7FFF}; exp[2] = 64'h0000_0000_0000_FFFF;
      ctrl_delay = 4'd0; ctrl_mode = 2'b01; dac_valid = 1'b0;
      adc_data_in = 64'hFFFF_FFFF_FFFF_FFFF; adc_valid_in = 1'b1;
      tick;
      for (int k = 0; k < 8; k++) begin
         checks++; if (adc_valid !== 1'b0 || adc_data !== 64'h0) begin errors++; $display("FAIL blank_out[%0d]: got valid=%b data=%h expected valid=0 data=0", k, adc_valid, adc_data); end
         checks++; if (status_switching !== 1'b1) begin errors++; $display("FAIL blank_switching[%0d]: got %b expected 1", k, status_switching); end
         tick;
      end
      checks++; if (status_mode !== 2'b01) begin errors++; $display("FAIL loop_mode: got %b expected 01", status_mode); end
      checks++; if (status_switching !== 1'b0) begin errors++; $display("FAIL loop_switching: got %b expected 0", status_switching); end
      for (int i = 0; i < 4; i++) begin
         if (i < 3) begin dac_data = din[i]; dac_valid = 1'b1; end
         else begin dac_data = '0; dac_valid = 1'b0; end
         tick;
         if (i >= 1) begin
            checks++; if (adc_data !== exp[i-1] || adc_valid !== 1'b1) begin errors++; $display("FAIL narrow[%0d]: got valid=%b data=%h expected valid=1 data=%h", i-1, adc_valid, adc_data, exp[i-1]); end
            $display("test_loopback_narrow: dac=%h out=%h", din[i-1][31:0], adc_data);
         end
      end
   endtask

   task automatic test_delay_gap;
      logic exp_valid, exp_gap;
      dac_valid = 1'b0; dac_data = '0; ctrl_delay = 4'd5;
      repeat (20) tick;
      status_clr = 1'b1;
      tick;
      checks++; if (status_gap !== 1'b1) begin errors++; $display("FAIL gap_set_wins: got %b expected 1", status_gap); end
      status_clr = 1'b0;
      dac_data = {64'h0, 32'h0001_0000, 32'h0}; dac_valid = 1'b1;
      tick;
      dac_data = '0; dac_valid = 1'b0;
      for (int n = 1; n <= 9; n++) begin
         if (n > 1) tick;
         exp_valid = (n == 7);
         exp_gap   = (n != 7);
         checks++; if (adc_valid !== exp_valid) begin errors++; $display("FAIL delay_valid[+%0d]: got %b expected %b", n, adc_valid, exp_valid); end
         checks++; if (status_gap !== exp_gap) begin errors++; $display("FAIL delay_gap[+%0d]: got %b expected %b", n, status_gap, exp_gap); end
         if (n == 7) begin
            checks++; if (adc_data !== 64'h0000_0000_0001_0000) begin errors++; $display("FAIL delay_data: got %h expected 0000000000010000", adc_data); end
         end
         $display("test_delay_gap: +%0d valid=%b gap=%b data=%h", n, adc_valid, status_gap, adc_data);
         status_clr = (n == 6);
      end
      status_clr = 1'b0;
   endtask

   task automatic test_ramp;
      ctrl_mode = 2'b10;
      tick;
      repeat (8) tick;
      for (int j = 0; j < 4; j++) begin
         checks++; if (adc_data[15:0] !== 16'(j) || adc_data[63:48] !== 16'(j + 3) || adc_valid !== 1'b1) begin
            errors++; $display("FAIL ramp[%0d]: got valid=%b lane0=%h lane3=%h expected valid=1 lane0=%h lane3=%h", j, adc_valid, adc_data[15:0], adc_data[63:48], 16'(j), 16'(j + 3));
         end
         checks++; if (status_mode !== 2'b10) begin errors++; $display("FAIL ramp_mode[%0d]: got %b expected 10", j, status_mode); end
         $display("test_ramp: lane0=%h lane3=%h", adc_data[15:0], adc_data[63:48]);
         tick;
      end
      repeat (65531) tick;
      checks++; if (adc_data[15:0] !== 16'hFFFF || adc_data[63:48] !== 16'h0002) begin errors++; $display("FAIL ramp_pre_wrap: got lane0=%h lane3=%h expected lane0=ffff lane3=0002", adc_data[15:0], adc_data[63:48]); end
      tick;
      checks++; if (adc_data[15:0] !== 16'h0000 || adc_data[63:48] !== 16'h0003) begin errors++; $display("FAIL ramp_wrap: got lane0=%h lane3=%h expected lane0=0000 lane3=0003", adc_data[15:0], adc_data[63:48]); end
      $display("test_ramp: wrap lane0=%h lane3=%h", adc_data[15:0], adc_data[63:48]);
   endtask

   task automatic test_blank_restart;
      ctrl_mode = 2'b01;
      tick;
      repeat (4) tick;
      checks++; if (status_switching !== 1'b1 || status_mode !== 2'b10) begin errors++; $display("FAIL restart_pre: got switching=%b mode=%b expected switching=1 mode=10", status_switching, status_mode); end
      ctrl_mode = 2'b11;
      tick;
      for (int k = 0; k < 8; k++) begin
         checks++; if (status_switching !== 1'b1 || adc_valid !== 1'b0 || adc_data !== 64'h0) begin
            errors++; $display("FAIL restart_blank[%0d]: got switching=%b valid=%b data=%h expected switching=1 valid=0 data=0", k, status_switching, adc_valid, adc_data);
         end
         tick;
      end
      checks++; if (status_mode !== 2'b11 || status_switching !== 1'b0) begin errors++; $display("FAIL restart_mode: got mode=%b switching=%b expected mode=11 switching=0", status_mode, status_switching); end
      checks++; if (adc_valid !== 1'b1 || adc_data !== 64'h0) begin errors++; $display("FAIL zero_out: got valid=%b data=%h expected valid=1 data=0", adc_valid, adc_data); end
      $display("test_blank_restart: mode=%b valid=%b data=%h", status_mode, adc_valid, adc_data);
   endtask

   task automatic test_reset_blank;
      ctrl_mode = 2'b01;
      tick; tick; tick;
      checks++; if (status_switching !== 1'b1) begin errors++; $display("FAIL rstblank_pre: got switching=%b expected 1", status_switching); end
      rst = 1'b1; ctrl_mode = 2'b00;
      adc_data_in = 64'h5555_AAAA_1357_2468; adc_valid_in = 1'b1;
      tick;
      checks++; if (status_switching !== 1'b0 || status_mode !== 2'b00) begin errors++; $display("FAIL rstblank_state: got switching=%b mode=%b expected switching=0 mode=00", status_switching, status_mode); end
      checks++; if (adc_valid !== 1'b0 || adc_data !== 64'h0) begin errors++; $display("FAIL rstblank_out: got valid=%b data=%h expected valid=0 data=0", adc_valid, adc_data); end
      rst = 1'b0;
      tick;
      checks++; if (adc_valid !== 1'b1 || adc_data !== 64'h5555_AAAA_1357_2468) begin errors++; $display("FAIL rstblank_bypass: got valid=%b data=%h expected valid=1 data=5555aaaa13572468", adc_valid, adc_data); end
      checks++; if (status_switching !== 1'b0) begin errors++; $display("FAIL rstblank_switching: got %b expected 0", status_switching); end
      $display("test_reset_blank: bypass out=%h", adc_data);
   endtask

   initial begin
      test_reset;
      test_bypass;
      test_loopback_narrow;
      test_delay_gap;
      test_ramp;
      test_blank_restart;
      test_reset_blank;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
